// File: rtl/sync_ram_clr.sv
// Single-clock RAM with one write port, a registered read port and a clear engine
// that fills every word with CLEAR_VAL after reset or on request.
module sync_ram_clr #(
    parameter int unsigned       DATA_W    = 4,
    parameter int unsigned       ADDR_W    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        StClear,
        StIdle
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              q_valid_q, q_valid_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic ptr_last;
    logic bypass;

    assign ptr_last = (ptr_q == {ADDR_W{1'b1}});
    // Write-first: a read of the word being written this edge returns the new data.
    assign bypass   = we && (wr_addr == rd_addr);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = data;

        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = CLEAR_VAL;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_last) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (clear) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end else begin
                    mem_we = we;
                    if (rd_en) begin
                        q_valid_d = 1'b1;
                        q_d       = bypass ? data : mem[rd_addr];
                    end
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClear;
            ptr_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    // Storage has no reset; the clear engine initialises it instead.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign busy    = (state_q == StClear);

endmodule

// File: tb/tb_sync_ram_clr.sv
// Randomised scoreboard bench for sync_ram_clr: a default 16x4 instance and a
// 32x8 instance with CLEAR_VAL 8'h3C, checked against an array-based model.
module tb_sync_ram_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_clear, a_we, a_rd_en, a_q_valid, a_busy;
    logic [3:0] a_wr_addr, a_rd_addr, a_data, a_q;

    logic       b_reset, b_clear, b_we, b_rd_en, b_q_valid, b_busy;
    logic [4:0] b_wr_addr, b_rd_addr;
    logic [7:0] b_data, b_q;

    sync_ram_clr u_dut_a (
        .clk     (clk),
        .reset   (a_reset),
        .clear   (a_clear),
        .we      (a_we),
        .wr_addr (a_wr_addr),
        .data    (a_data),
        .rd_en   (a_rd_en),
        .rd_addr (a_rd_addr),
        .q       (a_q),
        .q_valid (a_q_valid),
        .busy    (a_busy)
    );

    sync_ram_clr #(
        .DATA_W    (8),
        .ADDR_W    (5),
        .CLEAR_VAL (8'h3C)
    ) u_dut_b (
        .clk     (clk),
        .reset   (b_reset),
        .clear   (b_clear),
        .we      (b_we),
        .wr_addr (b_wr_addr),
        .data    (b_data),
        .rd_en   (b_rd_en),
        .rd_addr (b_rd_addr),
        .q       (b_q),
        .q_valid (b_q_valid),
        .busy    (b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word contents, edges of clear remaining, last read value.
    logic [7:0] mem_m [2][32];
    int         left_m [2];
    logic [7:0] q_m [2];
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    logic [7:0] mon_a, mon_b;

    function automatic int depth(input int s);
        return (s == 0) ? 16 : 32;
    endfunction

    function automatic logic [7:0] cval(input int s);
        return (s == 0) ? 8'h00 : 8'h3C;
    endfunction

    function automatic logic [7:0] dmask(input int s);
        return (s == 0) ? 8'h0F : 8'hFF;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: every q_valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (a_q_valid === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_valid: q_valid=1 q=%0h, expected no read result", a_q);
            end else begin
                mon_a = exp_a.pop_front();
                check("a_read", {4'h0, a_q}, mon_a);
            end
        end else if (exp_a.size() != 0) begin
            mon_a = exp_a.pop_front();
            check("a_missing_valid", {7'b0, a_q_valid}, 8'h01);
        end
    end

    always @(negedge clk) begin
        if (b_q_valid === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_valid: q_valid=1 q=%0h, expected no read result", b_q);
            end else begin
                mon_b = exp_b.pop_front();
                check("b_read", b_q, mon_b);
            end
        end else if (exp_b.size() != 0) begin
            mon_b = exp_b.pop_front();
            check("b_missing_valid", {7'b0, b_q_valid}, 8'h01);
        end
    end

    task automatic step(input int s, input bit rst, input bit clr, input bit we, input int wa,
                        input logic [7:0] d, input bit re, input int ra);
        logic [7:0] v;
        int         dp;
        dp = depth(s);
        wa = wa % dp;
        ra = ra % dp;
        d  = d & dmask(s);
        if (s == 0) begin
            a_reset = rst; a_clear = clr; a_we = we; a_rd_en = re;
            a_wr_addr = 4'(wa); a_rd_addr = 4'(ra); a_data = d[3:0];
        end else begin
            b_reset = rst; b_clear = clr; b_we = we; b_rd_en = re;
            b_wr_addr = 5'(wa); b_rd_addr = 5'(ra); b_data = d;
        end
        @(posedge clk);
        if (rst) begin
            left_m[s] = dp;
            q_m[s]    = 8'h00;
            for (int i = 0; i < dp; i++) mem_m[s][i] = cval(s);
        end else if (left_m[s] > 0) begin
            left_m[s]--;
        end else if (clr) begin
            left_m[s] = dp;
            for (int i = 0; i < dp; i++) mem_m[s][i] = cval(s);
        end else begin
            if (re) begin
                v = (we && wa == ra) ? d : mem_m[s][ra];
                q_m[s] = v;
                if (s == 0) exp_a.push_back(v);
                else        exp_b.push_back(v);
            end
            if (we) mem_m[s][wa] = d;
        end
        #1;
        if (s == 0) begin
            check("a_busy", {7'b0, a_busy}, {7'b0, left_m[0] > 0});
            check("a_q", {4'h0, a_q}, q_m[0]);
        end else begin
            check("b_busy", {7'b0, b_busy}, {7'b0, left_m[1] > 0});
            check("b_q", b_q, q_m[1]);
        end
    endtask

    task automatic idle(input int s);
        step(s, 0, 0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic rd(input int s, input int a);
        step(s, 0, 0, 0, 0, 8'h00, 1, a);
    endtask

    task automatic wr(input int s, input int a, input logic [7:0] d);
        step(s, 0, 0, 1, a, d, 0, 0);
    endtask

    // Counts edges until busy drops, optionally with port traffic that must be ignored.
    task automatic count_busy(input int s, input string name, input bit noise);
        int  n;
        logic bz;
        n  = 0;
        bz = (s == 0) ? a_busy : b_busy;
        while (bz === 1'b1 && n < 200) begin
            if (noise)
                step(s, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
                     8'($urandom), $urandom_range(0, 1), $urandom_range(0, 31));
            else
                idle(s);
            n++;
            bz = (s == 0) ? a_busy : b_busy;
        end
        check(name, 8'(n), 8'(depth(s)));
    endtask

    task automatic random_ops(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            step(s, $urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 1), $urandom_range(0, 31), 8'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 31));
        end
    endtask

    initial begin
        a_reset = 1'b1; a_clear = 1'b0; a_we = 1'b0; a_rd_en = 1'b0;
        a_wr_addr = '0; a_rd_addr = '0; a_data = '0;
        b_reset = 1'b1; b_clear = 1'b0; b_we = 1'b0; b_rd_en = 1'b0;
        b_wr_addr = '0; b_rd_addr = '0; b_data = '0;
        left_m[0] = 0; left_m[1] = 0; q_m[0] = 8'h00; q_m[1] = 8'h00;

        // Default instance: reset, initial clear, read back all zeroes.
        step(0, 1, 0, 0, 0, 8'h00, 0, 0);
        check("a_q_valid_reset", {7'b0, a_q_valid}, 8'h00);
        count_busy(0, "a_initial_clear_edges", 0);
        for (int i = 0; i < 16; i++) rd(0, i);
        idle(0);

        // Write then read, then a write without a read leaves q alone.
        wr(0, 3, 8'h0A);
        rd(0, 3);
        wr(0, 3, 8'h05);
        check("a_q_hold_after_write", {4'h0, a_q}, 8'h0A);
        idle(0);

        // Same-edge write/read: bypass on the same address, old data otherwise.
        step(0, 0, 0, 1, 7, 8'h09, 1, 7);
        idle(0);
        step(0, 0, 0, 1, 4, 8'h06, 1, 5);
        rd(0, 4);
        idle(0);

        // Fill with F, request a clear with traffic during busy, then all read 0.
        for (int i = 0; i < 16; i++) wr(0, i, 8'h0F);
        step(0, 0, 1, 1, 2, 8'h03, 1, 2);
        count_busy(0, "a_requested_clear_edges", 1);
        for (int i = 0; i < 16; i++) rd(0, i);
        idle(0);

        // Reset when the clear pointer is at 9 restarts the full clear.
        wr(0, 1, 8'h0C);
        rd(0, 1);
        step(0, 0, 1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 8'h00, 1, i);
        step(0, 1, 0, 0, 0, 8'h00, 1, 0);
        check("a_q_valid_mid_clear_reset", {7'b0, a_q_valid}, 8'h00);
        count_busy(0, "a_restarted_clear_edges", 0);

        // Reset during an idle read cancels it.
        wr(0, 6, 8'h0E);
        step(0, 1, 0, 0, 0, 8'h00, 1, 6);
        check("a_q_valid_reset_read", {7'b0, a_q_valid}, 8'h00);
        count_busy(0, "a_reset_read_clear_edges", 0);

        random_ops(0, 400);
        for (int i = 0; i < 20; i++) idle(0);

        // Wide instance: 32 words cleared to 3C.
        step(1, 1, 0, 0, 0, 8'h00, 0, 0);
        count_busy(1, "b_initial_clear_edges", 0);
        for (int i = 0; i < 32; i++) rd(1, i);
        wr(1, 31, 8'hFF);
        rd(1, 31);
        idle(1);
        random_ops(1, 300);
        for (int i = 0; i < 40; i++) idle(1);

        idle(0);
        idle(1);
        check("a_scoreboard_drained", 8'(exp_a.size()), 8'h00);
        check("b_scoreboard_drained", 8'(exp_b.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
